// File: rtl/ex_stage_scheduler.sv
// rtl/ex_stage_scheduler.sv - ID/EX pipeline sequencing controller (load-use, branch squash, multi-cycle hold)
//
// Purpose:
//   Generates the PC enable, IF/ID stall/flush and ID/EX bubble/hold controls for
//   the ID/EX boundary of an RV32 in-order pipeline. It detects load-use hazards,
//   squashes wrong-path instructions on a taken branch and holds the pipeline while
//   a multi-cycle EX operation (MUL/DIV) occupies the ALU.
//
// Optional feature macro: HAZARD_STATS_EN
//   Defined     : stall_cycles / flush_count are saturating event counters.
//   Not defined : both ports are tied to 0 and no counter flops exist.
//
// Ports:
//   clk              in   clock, all state updates on posedge
//   reset            in   asynchronous, active-high
//   id_valid         in   ID holds a valid instruction
//   id_rs1, id_rs2   in   ID source register indices
//   id_uses_rs1/rs2  in   ID instruction reads rs1 / rs2
//   id_multicycle    in   ID instruction is a multi-cycle ALU op
//   ex_valid         in   EX holds a valid instruction
//   ex_mem_read      in   EX instruction is a load
//   ex_rd            in   EX destination register
//   ex_branch_taken  in   EX resolved a taken branch/jump this cycle
//   pc_stall         out  hold PC
//   if_id_stall      out  hold IF/ID register
//   if_id_flush      out  clear IF/ID register to NOP
//   id_ex_bubble     out  load NOP into ID/EX
//   id_ex_hold       out  hold ID/EX contents
//   mc_busy          out  multi-cycle op executing
//   mc_done          out  one-cycle pulse: multi-cycle result valid this cycle
//   stall_cycles     out  stall-cycle counter
//   flush_count      out  flush-event counter

module ex_stage_scheduler #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int MC_LATENCY     = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      id_valid,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
    input  logic                      id_uses_rs1,
    input  logic                      id_uses_rs2,
    input  logic                      id_multicycle,
    input  logic                      ex_valid,
    input  logic                      ex_mem_read,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
    input  logic                      ex_branch_taken,
    output logic                      pc_stall,
    output logic                      if_id_stall,
    output logic                      if_id_flush,
    output logic                      id_ex_bubble,
    output logic                      id_ex_hold,
    output logic                      mc_busy,
    output logic                      mc_done,
    output logic [31:0]               stall_cycles,
    output logic [31:0]               flush_count
);

    localparam int CNT_W = $clog2(MC_LATENCY + 1);

    typedef enum logic {
        RUN     = 1'b0,
        MC_BUSY = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] mc_cnt_q;
    logic [CNT_W-1:0] mc_cnt_d;
    logic             lu;

    // x0 is hardwired zero, so a load targeting it can never create a dependency.
    assign lu = ex_valid && ex_mem_read && (ex_rd != '0) && id_valid &&
                ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                 (id_uses_rs2 && (id_rs2 == ex_rd)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= RUN;
            mc_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            mc_cnt_q <= mc_cnt_d;
        end
    end

    // mc_cnt holds the number of MC_BUSY cycles still to go, including the
    // current one; the op leaves EX in the cycle where it reads 1.
    always_comb begin
        state_d      = state_q;
        mc_cnt_d     = mc_cnt_q;
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        id_ex_hold   = 1'b0;
        mc_busy      = 1'b0;
        mc_done      = 1'b0;

        // Controls are forced low while reset is held, even though the
        // comparators above still see live inputs.
        if (!reset) begin
            case (state_q)
                RUN: begin
                    if (ex_branch_taken) begin
                        // Wrong-path instructions in IF/ID and ID are squashed;
                        // a squashed multi-cycle op must not start.
                        if_id_flush  = 1'b1;
                        id_ex_bubble = 1'b1;
                    end else if (lu) begin
                        pc_stall     = 1'b1;
                        if_id_stall  = 1'b1;
                        id_ex_bubble = 1'b1;
                    end else if (id_valid && id_multicycle) begin
                        state_d  = MC_BUSY;
                        mc_cnt_d = CNT_W'(MC_LATENCY);
                    end
                end
                MC_BUSY: begin
                    // The op in EX is neither a branch nor a load, so branch and
                    // load-use inputs are meaningless here and ignored.
                    pc_stall    = 1'b1;
                    if_id_stall = 1'b1;
                    id_ex_hold  = 1'b1;
                    mc_busy     = 1'b1;
                    if (mc_cnt_q == CNT_W'(1)) begin
                        mc_done  = 1'b1;
                        state_d  = RUN;
                        mc_cnt_d = '0;
                    end else begin
                        mc_cnt_d = mc_cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d  = RUN;
                    mc_cnt_d = '0;
                end
            endcase
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_q;
    logic [31:0] flush_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (pc_stall && (stall_q != 32'hFFFF_FFFF)) begin
                stall_q <= stall_q + 32'd1;
            end
            if (if_id_flush && (flush_q != 32'hFFFF_FFFF)) begin
                flush_q <= flush_q + 32'd1;
            end
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
`else
    assign stall_cycles = 32'd0;
    assign flush_count  = 32'd0;
`endif

endmodule

// File: tb/tb_ex_stage_scheduler.sv
// tb/tb_ex_stage_scheduler.sv - directed self-checking bench for ex_stage_scheduler

module tb_ex_stage_scheduler;

    localparam int RW = 5;

`ifdef HAZARD_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    // Control vector bit order: {pc_stall, if_id_stall, if_id_flush,
    //                            id_ex_bubble, id_ex_hold, mc_busy, mc_done}
    localparam logic [6:0] C_IDLE   = 7'b0000000;
    localparam logic [6:0] C_LU     = 7'b1101000;
    localparam logic [6:0] C_BRANCH = 7'b0011000;
    localparam logic [6:0] C_BUSY   = 7'b1100110;
    localparam logic [6:0] C_DONE   = 7'b1100111;

    logic          clk = 1'b0;
    logic          reset;
    logic          id_valid;
    logic [RW-1:0] id_rs1;
    logic [RW-1:0] id_rs2;
    logic          id_uses_rs1;
    logic          id_uses_rs2;
    logic          id_multicycle;
    logic          ex_valid;
    logic          ex_mem_read;
    logic [RW-1:0] ex_rd;
    logic          ex_branch_taken;
    logic          pc_stall;
    logic          if_id_stall;
    logic          if_id_flush;
    logic          id_ex_bubble;
    logic          id_ex_hold;
    logic          mc_busy;
    logic          mc_done;
    logic [31:0]   stall_cycles;
    logic [31:0]   flush_count;

    int checks   = 0;
    int failures = 0;
    int exp_stall = 0;
    int exp_flush = 0;

    logic [6:0] ctl;
    assign ctl = {pc_stall, if_id_stall, if_id_flush, id_ex_bubble,
                  id_ex_hold, mc_busy, mc_done};

    always #5 clk = ~clk;

    ex_stage_scheduler #(
        .REG_ADDR_WIDTH(RW),
        .MC_LATENCY    (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .id_valid       (id_valid),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_uses_rs1    (id_uses_rs1),
        .id_uses_rs2    (id_uses_rs2),
        .id_multicycle  (id_multicycle),
        .ex_valid       (ex_valid),
        .ex_mem_read    (ex_mem_read),
        .ex_rd          (ex_rd),
        .ex_branch_taken(ex_branch_taken),
        .pc_stall       (pc_stall),
        .if_id_stall    (if_id_stall),
        .if_id_flush    (if_id_flush),
        .id_ex_bubble   (id_ex_bubble),
        .id_ex_hold     (id_ex_hold),
        .mc_busy        (mc_busy),
        .mc_done        (mc_done),
        .stall_cycles   (stall_cycles),
        .flush_count    (flush_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ctl(input string tag, input logic [6:0] exp);
        chk(tag, {25'd0, ctl}, {25'd0, exp});
    endtask

    task automatic chk_cnt(input string tag);
        chk({tag, "_stall"}, stall_cycles, STATS ? 32'(exp_stall) : 32'd0);
        chk({tag, "_flush"}, flush_count,  STATS ? 32'(exp_flush) : 32'd0);
    endtask

    task automatic clear_in();
        id_valid        = 1'b0;
        id_rs1          = '0;
        id_rs2          = '0;
        id_uses_rs1     = 1'b0;
        id_uses_rs2     = 1'b0;
        id_multicycle   = 1'b0;
        ex_valid        = 1'b0;
        ex_mem_read     = 1'b0;
        ex_rd           = '0;
        ex_branch_taken = 1'b0;
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 ns later.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic set_mc_id();
        clear_in();
        id_valid      = 1'b1;
        id_multicycle = 1'b1;
    endtask

    task automatic set_load_use(input logic [RW-1:0] rd);
        clear_in();
        ex_valid    = 1'b1;
        ex_mem_read = 1'b1;
        ex_rd       = rd;
        id_valid    = 1'b1;
        id_rs1      = 5'd5;
        id_uses_rs1 = 1'b1;
    endtask

    initial begin
        // Reset asserted with live hazard/branch inputs: every output still 0.
        set_load_use(5'd5);
        ex_branch_taken = 1'b1;
        reset = 1'b1;
        #1;
        chk_ctl("reset_ctl", C_IDLE);
        chk_cnt("reset_cnt");
        next_cycle();
        clear_in();
        reset = 1'b0;
        #1 chk_ctl("idle", C_IDLE);

        // Load x5 in EX, ID reads rs1=x5: one stall cycle, then bubble advances.
        next_cycle();
        set_load_use(5'd5);
        #1 chk_ctl("lu_rs1", C_LU);
        exp_stall++;
        next_cycle();
        clear_in();
        id_valid    = 1'b1;
        id_rs1      = 5'd5;
        id_uses_rs1 = 1'b1;
        #1 chk_ctl("lu_after", C_IDLE);
        chk_cnt("lu_cnt");

        // Load to x0 never stalls.
        next_cycle();
        set_load_use(5'd0);
        id_rs1 = 5'd0;
        #1 chk_ctl("lu_x0", C_IDLE);

        // rs2 matches but is not read.
        next_cycle();
        set_load_use(5'd5);
        id_rs1      = 5'd3;
        id_rs2      = 5'd5;
        id_uses_rs2 = 1'b0;
        #1 chk_ctl("lu_rs2_unused", C_IDLE);

        // rs2 matches and is read.
        next_cycle();
        id_uses_rs2 = 1'b1;
        #1 chk_ctl("lu_rs2", C_LU);
        exp_stall++;

        // Load without mem_read flag is not a hazard.
        next_cycle();
        ex_mem_read = 1'b0;
        #1 chk_ctl("no_load", C_IDLE);

        // Taken branch outranks load-use.
        next_cycle();
        set_load_use(5'd5);
        ex_branch_taken = 1'b1;
        #1 chk_ctl("branch_lu", C_BRANCH);
        exp_flush++;
        next_cycle();
        clear_in();
        #1 chk_cnt("branch_cnt");

        // Taken branch squashes a multi-cycle op in ID: no MC entry.
        next_cycle();
        set_mc_id();
        ex_branch_taken = 1'b1;
        #1 chk_ctl("branch_mc", C_BRANCH);
        exp_flush++;
        next_cycle();
        clear_in();
        #1 chk_ctl("branch_mc_after", C_IDLE);

        // Single multi-cycle op, latency 4; branch/load-use ignored while busy.
        next_cycle();
        set_mc_id();
        #1 chk_ctl("mc_enter", C_IDLE);
        next_cycle();
        clear_in();
        #1 chk_ctl("mc_busy1", C_BUSY);
        next_cycle();
        set_load_use(5'd5);
        ex_branch_taken = 1'b1;
        #1 chk_ctl("mc_busy2_ignore", C_BUSY);
        next_cycle();
        clear_in();
        #1 chk_ctl("mc_busy3", C_BUSY);
        next_cycle();
        #1 chk_ctl("mc_done", C_DONE);
        exp_stall += 4;
        next_cycle();
        #1 chk_ctl("mc_exit", C_IDLE);
        chk_cnt("mc_cnt");

        // Back-to-back multi-cycle ops: one RUN cycle between them.
        next_cycle();
        set_mc_id();
        #1 chk_ctl("b2b_enter", C_IDLE);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            #1 chk_ctl($sformatf("b2b_a_busy%0d", i), C_BUSY);
        end
        next_cycle();
        #1 chk_ctl("b2b_a_done", C_DONE);
        next_cycle();
        #1 chk_ctl("b2b_gap_run", C_IDLE);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            if (i == 0) clear_in();
            #1 chk_ctl($sformatf("b2b_b_busy%0d", i), C_BUSY);
        end
        next_cycle();
        #1 chk_ctl("b2b_b_done", C_DONE);
        exp_stall += 8;
        next_cycle();
        #1 chk_ctl("b2b_exit", C_IDLE);
        chk_cnt("b2b_cnt");

        // Reset during the 2nd MC_BUSY cycle.
        next_cycle();
        set_mc_id();
        #1;
        next_cycle();
        clear_in();
        #1 chk_ctl("rst_busy1", C_BUSY);
        next_cycle();
        #1 chk_ctl("rst_busy2", C_BUSY);
        reset = 1'b1;
        #1 chk_ctl("rst_async", C_IDLE);
        exp_stall = 0;
        exp_flush = 0;
        chk_cnt("rst_async_cnt");
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            #1 chk_ctl($sformatf("rst_hold%0d", i), C_IDLE);
        end
        next_cycle();
        reset = 1'b0;
        #1 chk_ctl("rst_release", C_IDLE);
        chk_cnt("rst_release_cnt");
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            #1 chk_ctl($sformatf("rst_run%0d", i), C_IDLE);
        end

        // State is RUN again: a fresh load-use must stall normally.
        next_cycle();
        set_load_use(5'd5);
        #1 chk_ctl("post_rst_lu", C_LU);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
